time_fnd_display: RTL and testbench

//  Consumer of the packed 24-bit time words {hour[4:0],min[5:0],sec[5:0],msec[6:0]} from the watch top.

---
 rtl/time_fmt_pkg.sv | 54 +++++
 rtl/bcd_to_fnd.sv | 50 +++++
 rtl/time_fnd_display.sv | 149 ++++++++++++++
 tb/tb_time_fnd_display.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/time_fmt_pkg.sv
// Shared layout, range limits and segment fonts for the packed 24-bit time word
// {hour[4:0], min[5:0], sec[5:0], msec[6:0]} used by the display path.
package time_fmt_pkg;

  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int MSEC_MSB = 6;
  localparam int MSEC_LSB = 0;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MSEC_MAX = 7'd99;

  // Colon blink: dp on the hour.min page is lit during the first half second.
  localparam logic [6:0] DP_BLINK_LIMIT = 7'd50;

  localparam logic [3:0] CODE_DASH = 4'hE;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic {
    PAGE_SEC_MSEC = 1'b0,
    PAGE_HOUR_MIN = 1'b1
  } page_e;

  function automatic logic [3:0] tens_digit(input logic [6:0] value);
    logic [6:0] q;
    q = value / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] ones_digit(input logic [6:0] value);
    logic [6:0] r;
    r = value % 7'd10;
    return r[3:0];
  endfunction

endpackage

// File: rtl/bcd_to_fnd.sv
// Combinational decimal-digit to active-low 7-segment font, {dp,g,f,e,d,c,b,a}.
// A dash always shows with its decimal point dark; unknown codes blank the digit.
module bcd_to_fnd
  import time_fmt_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_dp,
  output logic [7:0] o_font
);

  logic [7:0] w_glyph;
  logic       w_is_digit;

  // Glyph lookup for the digit code
  always_comb begin
    w_glyph    = FONT_BLANK;
    w_is_digit = 1'b1;
    case (i_code)
      4'd0:      w_glyph = FONT_0;
      4'd1:      w_glyph = FONT_1;
      4'd2:      w_glyph = FONT_2;
      4'd3:      w_glyph = FONT_3;
      4'd4:      w_glyph = FONT_4;
      4'd5:      w_glyph = FONT_5;
      4'd6:      w_glyph = FONT_6;
      4'd7:      w_glyph = FONT_7;
      4'd8:      w_glyph = FONT_8;
      4'd9:      w_glyph = FONT_9;
      CODE_DASH: begin
        w_glyph    = FONT_DASH;
        w_is_digit = 1'b0;
      end
      default: begin
        w_glyph    = FONT_BLANK;
        w_is_digit = 1'b0;
      end
    endcase
  end

  // Merge the decimal point (active-low bit 7) onto real digits only
  always_comb begin
    o_font = w_glyph;
    if (i_dp && w_is_digit) begin
      o_font = {1'b0, w_glyph[6:0]};
    end else begin
      o_font = w_glyph;
    end
  end

endmodule

// File: rtl/time_fnd_display.sv
// Four-digit multiplexed 7-segment driver for watch/stopwatch time words; the
// shown word and page are latched once per scan frame so a frame never tears.
module time_fnd_display
  import time_fmt_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_watch_data,
  input  logic [23:0] i_stopwatch_data,
  input  logic        i_mode,
  input  logic        i_page,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_digit_sel;
  logic [23:0]      r_snap;
  page_e            r_page;
  logic [3:0]       r_fnd_com;
  logic [7:0]       r_fnd_font;

  logic       w_tick;
  logic       w_frame_end;
  logic [6:0] w_hour;
  logic [6:0] w_min;
  logic [6:0] w_sec;
  logic [6:0] w_msec;
  logic [6:0] w_hi_val;
  logic [6:0] w_lo_val;
  logic       w_hi_ok;
  logic       w_lo_ok;
  logic [3:0] w_code;
  logic       w_dp;
  logic [7:0] w_font;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_tick && (r_digit_sel == 2'd3);

  assign w_hour = {2'b00, r_snap[HOUR_MSB:HOUR_LSB]};
  assign w_min  = {1'b0,  r_snap[MIN_MSB:MIN_LSB]};
  assign w_sec  = {1'b0,  r_snap[SEC_MSB:SEC_LSB]};
  assign w_msec = r_snap[MSEC_MSB:MSEC_LSB];

  // Scan-rate divider: wraps on the tick cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Digit pointer advances once per tick, modulo four
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit_sel <= 2'd0;
    end else if (w_tick) begin
      r_digit_sel <= r_digit_sel + 2'd1;
    end else begin
      r_digit_sel <= r_digit_sel;
    end
  end

  // Frame snapshot: taken as the last digit goes out, so the next d0 uses it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= 24'd0;
      r_page <= PAGE_SEC_MSEC;
    end else if (w_frame_end) begin
      r_snap <= i_mode ? i_stopwatch_data : i_watch_data;
      r_page <= page_e'(i_page);
    end else begin
      r_snap <= r_snap;
      r_page <= r_page;
    end
  end

  // Field pair for the current page and its range check
  always_comb begin
    w_hi_val = w_sec;
    w_lo_val = w_msec;
    w_hi_ok  = 1'b1;
    w_lo_ok  = 1'b1;
    if (r_page == PAGE_HOUR_MIN) begin
      w_hi_val = w_hour;
      w_lo_val = w_min;
      w_hi_ok  = (w_hour <= HOUR_MAX);
      w_lo_ok  = (w_min  <= MIN_MAX);
    end else begin
      w_hi_val = w_sec;
      w_lo_val = w_msec;
      w_hi_ok  = (w_sec  <= SEC_MAX);
      w_lo_ok  = (w_msec <= MSEC_MAX);
    end
  end

  // Digit code and decimal point for the digit currently being scanned
  always_comb begin
    w_code = CODE_DASH;
    w_dp   = 1'b0;
    case (r_digit_sel)
      2'd3: w_code = w_hi_ok ? tens_digit(w_hi_val) : CODE_DASH;
      2'd2: begin
        w_code = w_hi_ok ? ones_digit(w_hi_val) : CODE_DASH;
        w_dp   = (r_page == PAGE_SEC_MSEC) || (w_msec < DP_BLINK_LIMIT);
      end
      2'd1: w_code = w_lo_ok ? tens_digit(w_lo_val) : CODE_DASH;
      2'd0: w_code = w_lo_ok ? ones_digit(w_lo_val) : CODE_DASH;
      default: begin
        w_code = CODE_DASH;
        w_dp   = 1'b0;
      end
    endcase
  end

  bcd_to_fnd u_bcd_to_fnd (
    .i_code (w_code),
    .i_dp   (w_dp),
    .o_font (w_font)
  );

  // Output registers: dark after reset, then refreshed on every tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fnd_com  <= 4'b1111;
      r_fnd_font <= FONT_BLANK;
    end else if (w_tick) begin
      r_fnd_com  <= ~(4'b0001 << r_digit_sel);
      r_fnd_font <= w_font;
    end else begin
      r_fnd_com  <= r_fnd_com;
      r_fnd_font <= r_fnd_font;
    end
  end

  assign o_fnd_com  = r_fnd_com;
  assign o_fnd_font = r_fnd_font;

endmodule

// File: tb/tb_time_fnd_display.sv
// Scoreboard bench for time_fnd_display at TICK_DIV = 10: stimulus pushes the
// hand-derived {com,font} per scanned digit, a monitor checks each new digit.
module tb_time_fnd_display;

  logic        clk;
  logic        rst;
  logic [23:0] i_watch_data;
  logic [23:0] i_stopwatch_data;
  logic        i_mode;
  logic        i_page;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_font;

  typedef struct {
    logic [3:0] com;
    logic [7:0] font;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;

  time_fnd_display #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_watch_data     (i_watch_data),
    .i_stopwatch_data (i_stopwatch_data),
    .i_mode           (i_mode),
    .i_page           (i_page),
    .o_fnd_com        (o_fnd_com),
    .o_fnd_font       (o_fnd_font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side count of rising edges since the last reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [23:0] pack(input int h, input int m, input int s, input int ms);
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [6:0] xx;
    hh = h[4:0];
    mm = m[5:0];
    ss = s[5:0];
    xx = ms[6:0];
    return {hh, mm, ss, xx};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got com=%b font=%h, expected com=%b font=%h",
               name, act[11:8], act[7:0], req[11:8], req[7:0]);
    end
  endtask

  // Push a frame's digits d0..d3 (fonts given in that order); n limits how many
  task automatic push_frame(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3, input int n);
    logic [7:0] fonts [4];
    fonts[0] = f0; fonts[1] = f1; fonts[2] = f2; fonts[3] = f3;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.com  = ~(4'b0001 << k);
      e.font = fonts[k];
      e.name = $sformatf("%s_d%0d", tag, k);
      exp_q.push_back(e);
    end
  endtask

  task automatic at_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: every change of the digit enable is a newly presented digit
  initial begin : monitor
    logic [3:0] prev_com;
    prev_com = 4'b1111;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_com = 4'b1111;
      end else if (o_fnd_com !== prev_com) begin
        prev_com = o_fnd_com;
        if (exp_q.size() == 0) begin
          check("unexpected_digit", {o_fnd_com, o_fnd_font}, 12'hFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.name, {o_fnd_com, o_fnd_font}, {e.com, e.font});
        end
      end
    end
  end

  initial begin : stimulus
    rst              = 1'b0;
    i_watch_data     = pack(12, 34, 56, 78);
    i_stopwatch_data = pack(1, 2, 3, 45);
    i_mode           = 1'b0;
    i_page           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dark", {o_fnd_com, o_fnd_font}, {4'b1111, 8'hFF});

    push_frame("f0_zero", 8'hC0, 8'hC0, 8'h40, 8'hC0, 4);
    push_frame("f1_p0", 8'h80, 8'hF8, 8'h02, 8'h92, 4);
    push_frame("f2_p1", 8'h99, 8'hB0, 8'hA4, 8'hF9, 4);
    rst = 1'b1;
    at_edge(5);
    check("dark_before_tick", {o_fnd_com, o_fnd_font}, {4'b1111, 8'hFF});
    at_edge(9);
    check("dark_last_cycle", {o_fnd_com, o_fnd_font}, {4'b1111, 8'hFF});

    at_edge(45);
    i_page = 1'b1;
    at_edge(85);
    i_watch_data = pack(12, 34, 56, 20);
    push_frame("f3_blink", 8'h99, 8'hB0, 8'h24, 8'hF9, 4);
    at_edge(125);
    i_mode = 1'b1;
    i_page = 1'b0;
    push_frame("f4_sw", 8'h92, 8'h99, 8'h30, 8'hC0, 4);
    at_edge(195);
    i_mode       = 1'b0;
    i_watch_data = pack(12, 34, 63, 78);
    push_frame("f5_sec63", 8'h80, 8'hF8, 8'hBF, 8'hBF, 4);
    at_edge(205);
    i_watch_data = pack(23, 59, 59, 99);
    i_page       = 1'b1;
    push_frame("f6_max", 8'h90, 8'h92, 8'hB0, 8'hA4, 4);
    at_edge(245);
    i_watch_data = pack(24, 59, 0, 49);
    push_frame("f7_hour24", 8'h90, 8'h92, 8'hBF, 8'hBF, 4);
    at_edge(285);
    i_watch_data = pack(0, 0, 0, 100);
    i_page       = 1'b0;
    push_frame("f8_ms100", 8'hBF, 8'hBF, 8'h40, 8'hC0, 3);

    at_edge(355);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {o_fnd_com, o_fnd_font}, {4'b1111, 8'hFF});
    repeat (2) @(negedge clk);
    check("reset_hold", {o_fnd_com, o_fnd_font}, {4'b1111, 8'hFF});
    check("queue_drained_at_reset", {4'd0, 8'(exp_q.size())}, 12'd0);

    push_frame("r0_zero", 8'hC0, 8'hC0, 8'h40, 8'hC0, 4);
    push_frame("r1_ms100", 8'hBF, 8'hBF, 8'h40, 8'hC0, 4);
    rst = 1'b1;
    at_edge(9);
    check("restart_dark", {o_fnd_com, o_fnd_font}, {4'b1111, 8'hFF});
    at_edge(85);
    check("queue_drained_end", {4'd0, 8'(exp_q.size())}, 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
